// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } ldr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that shifts its MSB out one bit per enabled cycle and
// reloads from the host as the last valid bit leaves.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [CNT_W-1:0]  rem_i,
  output logic              msb_o,
  output logic              empty_o,
  output logic              ready_o,
  output logic [CNT_W-1:0]  take_o
);

  localparam int BCW = clog2(WORD_W + 1);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BCW-1:0]    cnt_q, cnt_d;
  logic [BCW-1:0]    take;

  // Only the first rem_i bits of a word are meaningful; the rest fall off the low end.
  always_comb begin
    take = BCW'(rem_i);
    if (int'(rem_i) >= WORD_W) take = BCW'(WORD_W);
  end

  assign take_o  = CNT_W'(take);
  assign msb_o   = buf_q[WORD_W-1];
  assign empty_o = (cnt_q == '0);
  assign ready_o = ((cnt_q == '0) || ((cnt_q == BCW'(1)) && shift_i)) && (rem_i != '0);

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      buf_d = data_i;
      cnt_d = take;
    end else if (shift_i) begin
      buf_d = buf_q << 1;
      cnt_d = cnt_q - BCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// Drives the eFPGA configuration-chain head from a host word stream, gates
// the chain clock for exactly CHAIN_LEN shifts, and optionally parity-verifies.
module ccff_stream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

  ldr_state_e       state_q;
  logic [CNT_W-1:0] rem_q, bit_cnt_q, take;
  logic             verify_q, parity_q, tparity_q, verify_err_q;
  logic             ser_msb, ser_empty, ser_ready, ser_clr, load_shift, accept;

  // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_valid may not depend on cfg_ready, and abort withdraws ready that cycle.
  assign cfg_ready  = (state_q == ST_LOAD) && ser_ready && !abort;
  assign accept     = cfg_valid && cfg_ready;
  assign load_shift = (state_q == ST_LOAD) && !ser_empty;
  assign cfg_clk_en = load_shift || (state_q == ST_VERIFY);
  assign ser_clr    = (state_q != ST_LOAD) || abort;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign verify_err = verify_err_q;

  always_comb begin
    ccff_head = 1'b0;
    case (state_q)
      ST_LOAD:   ccff_head = ser_msb;
      ST_VERIFY: ccff_head = ccff_tail;
      default:   ccff_head = 1'b0;
    endcase
  end

  ccff_word_serializer #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) u_ser (
    .clk    (prog_clk),
    .rst_n  (pReset_n),
    .clr_i  (ser_clr),
    .load_i (accept),
    .shift_i(load_shift),
    .data_i (cfg_data),
    .rem_i  (rem_q),
    .msb_o  (ser_msb),
    .empty_o(ser_empty),
    .ready_o(ser_ready),
    .take_o (take)
  );

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      bit_cnt_q    <= '0;
      verify_q     <= 1'b0;
      parity_q     <= 1'b0;
      tparity_q    <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_LOAD;
            verify_q     <= verify_en;
            verify_err_q <= 1'b0;
            parity_q     <= 1'b0;
            tparity_q    <= 1'b0;
            rem_q        <= FULL;
            bit_cnt_q    <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            if (accept) rem_q <= rem_q - take;
            if (load_shift) begin
              parity_q <= parity_q ^ ser_msb;
              if (bit_cnt_q == LAST) begin
                bit_cnt_q <= '0;
                state_q   <= verify_q ? ST_VERIFY : ST_DONE;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        ST_VERIFY: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            // Recirculation leaves the chain intact; its bits stream past the tail once.
            tparity_q <= tparity_q ^ ccff_tail;
            if (bit_cnt_q == LAST) begin
              bit_cnt_q    <= '0;
              verify_err_q <= (tparity_q ^ ccff_tail) != parity_q;
              state_q      <= ST_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader: a 4-flop chain instance and a
// 12-flop chain instance, each fed by an enable-gated behavioural chain.
module tb_ccff_stream_loader;

  logic       prog_clk = 1'b0;
  logic       pReset_n;
  logic       start, verify_en, abort, cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready, ccff_head, ccff_tail, cfg_clk_en, busy, done, verify_err;
  logic [3:0] chain = 4'b0000;
  logic       flip_req;

  logic        start2, verify_en2, abort2, cfg_valid2;
  logic [7:0]  cfg_data2;
  logic        cfg_ready2, ccff_head2, ccff_tail2, cfg_clk_en2, busy2, done2, verify_err2;
  logic [11:0] chain2 = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;
  int en_edges = 0, accepts = 0, done_cnt = 0;
  int en2_edges = 0, accepts2 = 0, done2_cnt = 0, low2_cnt = 0;
  int e0, a0, d0, l0;
  logic [7:0] exp_en_t, exp_head_t, exp_done_t, exp_busy_t, exp_ready_t;

  assign ccff_tail  = chain[3];
  assign ccff_tail2 = chain2[11];

  always #5 prog_clk = ~prog_clk;

  ccff_stream_loader #(.CHAIN_LEN(4), .WORD_W(8)) dut (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .start     (start),
    .verify_en (verify_en),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .cfg_clk_en(cfg_clk_en),
    .busy      (busy),
    .done      (done),
    .verify_err(verify_err)
  );

  ccff_stream_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .start     (start2),
    .verify_en (verify_en2),
    .abort     (abort2),
    .cfg_data  (cfg_data2),
    .cfg_valid (cfg_valid2),
    .cfg_ready (cfg_ready2),
    .ccff_head (ccff_head2),
    .ccff_tail (ccff_tail2),
    .cfg_clk_en(cfg_clk_en2),
    .busy      (busy2),
    .done      (done2),
    .verify_err(verify_err2)
  );

  // Chain models and event counters; flip_req corrupts flop 1 ahead of the shift.
  always @(posedge prog_clk) begin
    if (cfg_clk_en) begin
      en_edges++;
      chain <= {chain[2], chain[1] ^ flip_req, chain[0], ccff_head};
    end else if (flip_req) begin
      chain[1] <= ~chain[1];
    end
    if (cfg_valid && cfg_ready) accepts++;
    if (done) done_cnt++;
    if (cfg_clk_en2) begin
      en2_edges++;
      chain2 <= {chain2[10:0], ccff_head2};
    end
    if (cfg_valid2 && cfg_ready2) accepts2++;
    if (done2) done2_cnt++;
    if (busy2 && !cfg_clk_en2 && !done2) low2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge prog_clk);
  endtask

  // Called at a negedge; start is sampled on the next edge, returns in cycle 1.
  task automatic kick(input logic [7:0] w, input logic ven);
    start     = 1'b1;
    verify_en = ven;
    cfg_data  = w;
    cfg_valid = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic snap();
    e0 = en_edges;
    a0 = accepts;
    d0 = done_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset_n = 1'b0;
    start = 1'b0; verify_en = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    start2 = 1'b0; verify_en2 = 1'b0; abort2 = 1'b0; cfg_valid2 = 1'b0; cfg_data2 = 8'h00;
    flip_req = 1'b0;
    repeat (3) tick();
    check("reset_outs", {cfg_clk_en, busy, ccff_head, cfg_ready, done, verify_err}, 6'b0);
    check("reset_outs12", {cfg_clk_en2, busy2, ccff_head2, cfg_ready2, done2, verify_err2}, 6'b0);
    pReset_n = 1'b1;
    tick();
    check("post_reset_busy", busy, 1'b0);

    // Single load of 8'hA5, no verify: per-cycle timing table.
    exp_en_t = 8'h3C; exp_head_t = 8'h14; exp_done_t = 8'h40;
    exp_busy_t = 8'h7E; exp_ready_t = 8'h02;
    snap();
    kick(8'hA5, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      check($sformatf("s1_en_c%0d", k), cfg_clk_en, exp_en_t[k]);
      check($sformatf("s1_head_c%0d", k), ccff_head, exp_head_t[k]);
      check($sformatf("s1_done_c%0d", k), done, exp_done_t[k]);
      check($sformatf("s1_busy_c%0d", k), busy, exp_busy_t[k]);
      check($sformatf("s1_ready_c%0d", k), cfg_ready, exp_ready_t[k]);
    end
    cfg_valid = 1'b0;
    check("s1_chain", chain, 4'b1010);
    check("s1_en_edges", en_edges - e0, 4);
    check("s1_accepts", accepts - a0, 1);
    check("s1_done_cnt", done_cnt - d0, 1);

    // Verify pass on a clean chain.
    snap();
    kick(8'hA5, 1'b1);
    repeat (5) tick();
    check("s3_head_is_tail_c6", ccff_head, 1'b1);
    check("s3_en_c6", cfg_clk_en, 1'b1);
    repeat (4) tick();
    check("s3_done_c10", done, 1'b1);
    check("s3_en_c10", cfg_clk_en, 1'b0);
    check("s3_verify_err", verify_err, 1'b0);
    tick();
    check("s3_busy_c11", busy, 1'b0);
    cfg_valid = 1'b0;
    check("s3_chain", chain, 4'b1010);
    check("s3_en_edges", en_edges - e0, 8);
    check("s3_done_cnt", done_cnt - d0, 1);

    // Verify pass with flop 1 corrupted as VERIFY begins.
    kick(8'hA5, 1'b1);
    repeat (5) tick();
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
    repeat (3) tick();
    check("s4_done_c10", done, 1'b1);
    check("s4_verify_err", verify_err, 1'b1);
    cfg_valid = 1'b0;
    repeat (3) tick();
    check("s4_verify_err_sticky", verify_err, 1'b1);
    check("s4_idle", busy, 1'b0);

    // Abort after two shifts.
    snap();
    kick(8'hA5, 1'b0);
    check("s5_err_cleared", verify_err, 1'b0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s5_en_after_abort", cfg_clk_en, 1'b0);
    check("s5_busy_after_abort", busy, 1'b0);
    check("s5_done_after_abort", done, 1'b0);
    repeat (2) tick();
    cfg_valid = 1'b0;
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_en_edges", en_edges - e0, 3);

    // Abort in the cycle a word is offered: nothing is accepted.
    snap();
    kick(8'hA5, 1'b0);
    abort = 1'b1;
    #1;
    check("s5_ready_during_abort", cfg_ready, 1'b0);
    tick();
    abort = 1'b0;
    cfg_valid = 1'b0;
    check("s5_busy_after_abort2", busy, 1'b0);
    check("s5_no_accept", accepts - a0, 0);

    // Normal load after aborts.
    snap();
    kick(8'h3C, 1'b0);
    repeat (6) tick();
    cfg_valid = 1'b0;
    check("s5_reload_chain", chain, 4'b0011);
    check("s5_reload_done", done_cnt - d0, 1);
    check("s5_reload_busy", busy, 1'b0);

    // Asynchronous reset mid-load, off the clock edge.
    kick(8'hA5, 1'b0);
    tick();
    check("s6_head_before_reset", ccff_head, 1'b1);
    check("s6_en_before_reset", cfg_clk_en, 1'b1);
    #2 pReset_n = 1'b0;
    #1;
    check("s6_outs_in_reset", {cfg_clk_en, busy, ccff_head, cfg_ready, done, verify_err}, 6'b0);
    tick();
    pReset_n = 1'b1;
    cfg_valid = 1'b0;
    tick();
    snap();
    kick(8'hA5, 1'b0);
    repeat (6) tick();
    cfg_valid = 1'b0;
    check("s6_chain", chain, 4'b1010);
    check("s6_en_edges", en_edges - e0, 4);
    check("s6_done_cnt", done_cnt - d0, 1);
    check("s6_busy", busy, 1'b0);

    // CHAIN_LEN=12: 8'hF0 then 8'h3C withheld, leaving a five-cycle bubble.
    e0 = en2_edges; a0 = accepts2; d0 = done2_cnt; l0 = low2_cnt;
    start2 = 1'b1; cfg_data2 = 8'hF0; cfg_valid2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("s2_ready_c1", cfg_ready2, 1'b1);
    tick();
    cfg_valid2 = 1'b0;
    cfg_data2  = 8'h3C;
    check("s2_en_c2", cfg_clk_en2, 1'b1);
    repeat (8) tick();
    check("s2_en_c10", cfg_clk_en2, 1'b0);
    check("s2_chain_c10", chain2, 12'h0F0);
    repeat (2) tick();
    check("s2_ready_c12", cfg_ready2, 1'b1);
    tick();
    check("s2_en_c13", cfg_clk_en2, 1'b0);
    check("s2_chain_c13", chain2, 12'h0F0);
    tick();
    cfg_valid2 = 1'b1;
    check("s2_en_c14", cfg_clk_en2, 1'b0);
    tick();
    cfg_valid2 = 1'b0;
    check("s2_en_c15", cfg_clk_en2, 1'b1);
    repeat (4) tick();
    check("s2_done_c19", done2, 1'b1);
    tick();
    check("s2_busy_c20", busy2, 1'b0);
    check("s2_chain", chain2, 12'hF03);
    check("s2_en_edges", en2_edges - e0, 12);
    check("s2_accepts", accepts2 - a0, 2);
    check("s2_low_cycles", low2_cnt - l0, 6);
    check("s2_done_cnt", done2_cnt - d0, 1);
    check("s2_verify_err", verify_err2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
